// File: rtl/fifo_wr_arb_if.sv
// fifo_wr_arb_if: requester-side and FIFO write-port signals shared by the write arbiter
interface fifo_wr_arb_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]         req;
    logic [NREQ*WIDTH-1:0]   req_data;
    logic                    fifo_full;
    logic                    fifo_wr_en;
    logic [WIDTH-1:0]        fifo_wr_data;
    logic [NREQ-1:0]         gnt;
    logic [NREQ-1:0]         ack;
    logic                    busy;
    logic [$clog2(NREQ)-1:0] owner;
    modport master (
        input  req, req_data, fifo_full,
        output fifo_wr_en, fifo_wr_data, gnt, ack, busy, owner
    );
    modport slave (
        output req, req_data, fifo_full,
        input  fifo_wr_en, fifo_wr_data, gnt, ack, busy, owner
    );
endinterface

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin burst arbiter sharing one FIFO write port among NREQ requesters
module fifo_wr_arb #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input logic          wr_clk,
    input logic          wr_rst,
    fifo_wr_arb_if.master bus
);
    localparam int OW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d, rr_q, rr_d, pick;
    logic [BW-1:0] beat_q, beat_d;
    logic          w, rel;

    function automatic logic [OW-1:0] wrap_add(input logic [OW-1:0] a, input int b);
        int s = int'(a) + b;
        return OW'(s >= NREQ ? s - NREQ : s);
    endfunction

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        w   = state_q == BURST && bus.req[owner_q] && !bus.fifo_full;
        rel = state_q == BURST && (!bus.req[owner_q] || (w && beat_q == BW'(MAX_BURST - 1)));
        pick = rr_q;
        // Descending scan so the smallest offset from rr_q wins
        for (int k = NREQ - 1; k >= 0; k--)
            if (bus.req[wrap_add(rr_q, k)]) pick = wrap_add(rr_q, k);
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        beat_d  = beat_q;
        if (state_q == IDLE && |bus.req) begin
            state_d = BURST;
            owner_d = pick;
            beat_d  = '0;
        end else if (rel) begin
            state_d = IDLE;
            owner_d = '0;
            rr_d    = wrap_add(owner_q, 1);
            beat_d  = '0;
        end else if (w) begin
            beat_d = beat_q + 1'b1;
        end
    end

    always_comb begin
        bus.busy         = state_q == BURST;
        bus.owner        = owner_q;
        bus.gnt          = bus.busy ? NREQ'(1) << owner_q : '0;
        bus.ack          = w ? bus.gnt : '0;
        bus.fifo_wr_en   = w;
        bus.fifo_wr_data = bus.busy ? bus.req_data[owner_q*WIDTH +: WIDTH] : '0;
    end
endmodule
